load_store_unit: RTL and testbench

Initiator side of the data-memory port. Accepts one load/store request at a time from the CPU datapath and drives the memory's Address/WriteData/tipols/MemRead/MemWrite lines, then returns a completion to the CPU. Word accesses map directly onto memory. Byte loads use the memory byte mode, and byte stores are built as a read-modify-write of the containing word, because memory writes are word-only. Byte order is big-endian: the byte at address A is bits [31:24] of the word at A.

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// CPU request/response channel and data-memory port of the load/store unit.
// master drives the request (CPU) or the memory strobes (LSU); slave answers.
interface lsu_cpu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_type, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_type, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  tipols;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, tipols, MemRead, MemWrite,
    input  ReadData
  );
  modport slave (
    input  Address, WriteData, tipols, MemRead, MemWrite,
    output ReadData
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time; misaligned 1, word store 2, load 3, byte store 4 cycles to resp.
// req_ready only in IDLE (no pipelining); responses are single-cycle pulses with no backpressure.
module load_store_unit (
  input  logic      clock,
  input  logic      reset,
  lsu_cpu_if.slave  cpu,
  lsu_mem_if.master mem
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
  } state_t;

  typedef struct packed {
    logic       is_byte;
    logic       sext;
    logic [1:0] lane;
    logic [7:0] wbyte;
  } req_t;

  state_t state;
  req_t   req;
  req_t   req_in;
  logic   misaligned_in;

  always_comb begin
    req_in         = '0;
    req_in.is_byte = (cpu.req_type == 2'b01) || (cpu.req_type == 2'b10);
    req_in.sext    = (cpu.req_type == 2'b10);
    req_in.lane    = cpu.req_addr[1:0];
    req_in.wbyte   = cpu.req_wdata[7:0];
    misaligned_in  = !req_in.is_byte && (cpu.req_addr[1:0] != 2'b00);
  end

  // Big-endian lanes: address offset 0 is the most significant byte.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      req            <= '0;
      cpu.req_ready  <= 1'b1;
      cpu.resp_valid <= 1'b0;
      cpu.resp_rdata <= '0;
      cpu.resp_err   <= 1'b0;
      mem.Address    <= '0;
      mem.WriteData  <= '0;
      mem.tipols     <= 2'b00;
      mem.MemRead    <= 1'b0;
      mem.MemWrite   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req_valid && cpu.req_ready) begin
            req           <= req_in;
            cpu.req_ready <= 1'b0;
            if (misaligned_in) begin
              state          <= RESP;
              cpu.resp_valid <= 1'b1;
              cpu.resp_err   <= 1'b1;
            end else if (!cpu.req_write) begin
              state       <= RD;
              mem.MemRead <= 1'b1;
              mem.tipols  <= req_in.is_byte ? 2'b01 : 2'b00;
              mem.Address <= cpu.req_addr;
            end else if (!req_in.is_byte) begin
              state         <= WR;
              mem.MemWrite  <= 1'b1;
              mem.tipols    <= 2'b00;
              mem.Address   <= cpu.req_addr;
              mem.WriteData <= cpu.req_wdata;
            end else begin
              state       <= RMW_RD;
              mem.MemRead <= 1'b1;
              mem.tipols  <= 2'b00;
              mem.Address <= {cpu.req_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          mem.MemRead <= 1'b0;
          state       <= RD_WAIT;
        end
        RD_WAIT: begin
          cpu.resp_valid <= 1'b1;
          if (!req.is_byte)
            cpu.resp_rdata <= mem.ReadData;
          else
            cpu.resp_rdata <= {{24{req.sext & mem.ReadData[7]}}, mem.ReadData[7:0]};
          state <= RESP;
        end
        WR: begin
          mem.MemWrite   <= 1'b0;
          cpu.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RMW_RD: begin
          mem.MemRead <= 1'b0;
          state       <= RMW_WAIT;
        end
        RMW_WAIT: begin
          mem.WriteData <= merge_byte(mem.ReadData, req.lane, req.wbyte);
          mem.MemWrite  <= 1'b1;
          state         <= RMW_WR;
        end
        RMW_WR: begin
          mem.MemWrite   <= 1'b0;
          cpu.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          cpu.resp_valid <= 1'b0;
          cpu.resp_rdata <= '0;
          cpu.resp_err   <= 1'b0;
          cpu.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table with a word-addressed memory model, plus
// back-to-back issue and mid-transaction reset sequences.
module tb_load_store_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lsu_cpu_if cpu ();
  lsu_mem_if mem ();

  load_store_unit dut (.clock(clock), .reset(reset), .cpu(cpu), .mem(mem));

  logic [31:0] mem_arr [0:15];

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Memory: read data one cycle after the strobe, byte mode returns the addressed byte zero-extended.
  always @(posedge clock) begin
    if (mem.MemWrite) mem_arr[mem.Address[5:2]] <= mem.WriteData;
    if (mem.MemRead) begin
      if (mem.tipols == 2'b01)
        mem.ReadData <= {24'b0, pick_byte(mem_arr[mem.Address[5:2]], mem.Address[1:0])};
      else
        mem.ReadData <= mem_arr[mem.Address[5:2]];
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nrd, nwr, overlap;
  logic [31:0] rd_addr, wr_addr, wr_dat;
  logic [1:0]  rd_tip;
  int resp_cycs[$];

  always @(posedge clock) begin
    #2;
    cyc++;
    if (mem.MemRead) begin nrd++; rd_addr = mem.Address; rd_tip = mem.tipols; end
    if (mem.MemWrite) begin nwr++; wr_addr = mem.Address; wr_dat = mem.WriteData; end
    if (mem.MemRead && mem.MemWrite) overlap++;
    if (cpu.resp_valid) resp_cycs.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    logic [1:0]  mtip;
    logic [31:0] mwdat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic e, input int lat, input int nr, input int nw,
                              input logic [31:0] ma, input logic [1:0] mt, input logic [31:0] mw);
    vec_t v;
    v.write = w; v.typ = t; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = e;
    v.lat = lat; v.nrd = nr; v.nwr = nw; v.maddr = ma; v.mtip = mt; v.mwdat = mw;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    bit acc, got, rdy;
    int lat;
    nrd = 0; nwr = 0;
    cpu.req_write = v.write; cpu.req_type = v.typ;
    cpu.req_addr = v.addr; cpu.req_wdata = v.wdata; cpu.req_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      rdy = cpu.req_ready;
      @(posedge clock); #1;
      acc = rdy;
    end
    // Scramble request fields after acceptance; the unit must have latched them.
    cpu.req_valid = 1'b0;
    cpu.req_write = 1'($urandom);
    cpu.req_type  = 2'($urandom);
    cpu.req_addr  = $urandom;
    cpu.req_wdata = $urandom;
    lat = 1;
    got = cpu.resp_valid;
    while (!got && lat < 12) begin
      @(posedge clock); #1;
      lat++;
      got = cpu.resp_valid;
    end
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_rdata"}, cpu.resp_rdata, v.rdata);
    chk({tag, "_err"}, 32'(cpu.resp_err), 32'(v.err));
    chk({tag, "_nread"}, 32'(nrd), 32'(v.nrd));
    chk({tag, "_nwrite"}, 32'(nwr), 32'(v.nwr));
    if (v.nrd > 0) begin
      chk({tag, "_rd_addr"}, rd_addr, v.maddr);
      chk({tag, "_rd_tipols"}, 32'(rd_tip), 32'(v.mtip));
    end
    if (v.nwr > 0) begin
      chk({tag, "_wr_addr"}, wr_addr, v.maddr);
      chk({tag, "_wr_data"}, wr_dat, v.mwdat);
    end
    @(posedge clock); #1;
    chk({tag, "_resp_drop"}, 32'(cpu.resp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(cpu.req_ready), 32'd1);
  endtask

  initial begin
    int accepts;
    bit rdy;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
    mem_arr[4] = 32'h11223344;
    mem_arr[6] = 32'hCAFEF00D;
    cpu.req_valid = 1'b0; cpu.req_write = 1'b0; cpu.req_type = 2'b00;
    cpu.req_addr = '0; cpu.req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("rst_req_ready", 32'(cpu.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu.resp_valid), 32'd0);
    chk("rst_resp_rdata", cpu.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(cpu.resp_err), 32'd0);
    chk("rst_address", mem.Address, 32'd0);
    chk("rst_writedata", mem.WriteData, 32'd0);
    chk("rst_tipols", 32'(mem.tipols), 32'd0);
    chk("rst_memread", 32'(mem.MemRead), 32'd0);
    chk("rst_memwrite", 32'(mem.MemWrite), 32'd0);

    //                 w  typ    addr      wdata          rdata        err lat rd wr maddr  mtip  mwdat
    vecs.push_back(mk(0, 2'd0, 32'h10, 32'h0,        32'h11223344, 0, 3, 1, 0, 32'h10, 2'd0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 32'h10, 32'h11223380, 32'h0,        0, 2, 0, 1, 32'h10, 2'd0, 32'h11223380));
    vecs.push_back(mk(0, 2'd2, 32'h13, 32'h0,        32'hFFFFFF80, 0, 3, 1, 0, 32'h13, 2'd1, 32'h0));
    vecs.push_back(mk(0, 2'd1, 32'h13, 32'h0,        32'h00000080, 0, 3, 1, 0, 32'h13, 2'd1, 32'h0));
    vecs.push_back(mk(0, 2'd1, 32'h10, 32'h0,        32'h00000011, 0, 3, 1, 0, 32'h10, 2'd1, 32'h0));
    vecs.push_back(mk(0, 2'd2, 32'h12, 32'h0,        32'h00000033, 0, 3, 1, 0, 32'h12, 2'd1, 32'h0));
    vecs.push_back(mk(1, 2'd0, 32'h10, 32'h11223344, 32'h0,        0, 2, 0, 1, 32'h10, 2'd0, 32'h11223344));
    vecs.push_back(mk(1, 2'd1, 32'h11, 32'h000000AB, 32'h0,        0, 4, 1, 1, 32'h10, 2'd0, 32'h11AB3344));
    vecs.push_back(mk(0, 2'd0, 32'h10, 32'h0,        32'h11AB3344, 0, 3, 1, 0, 32'h10, 2'd0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 32'h13, 32'h0000005A, 32'h0,        0, 4, 1, 1, 32'h10, 2'd0, 32'h11AB335A));
    vecs.push_back(mk(1, 2'd1, 32'h10, 32'h000000C3, 32'h0,        0, 4, 1, 1, 32'h10, 2'd0, 32'hC3AB335A));
    vecs.push_back(mk(0, 2'd3, 32'h10, 32'h0,        32'hC3AB335A, 0, 3, 1, 0, 32'h10, 2'd0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 32'h14, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'h14, 2'd0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2'd0, 32'h16, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,  2'd0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 32'h15, 32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0,  2'd0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 32'h14, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 32'h14, 2'd0, 32'h0));
    vecs.push_back(mk(0, 2'd2, 32'h15, 32'h0,        32'hFFFFFFAD, 0, 3, 1, 0, 32'h15, 2'd1, 32'h0));
    vecs.push_back(mk(1, 2'd1, 32'h16, 32'hFFFFFF12, 32'h0,        0, 4, 1, 1, 32'h14, 2'd0, 32'hDEAD12EF));
    vecs.push_back(mk(0, 2'd0, 32'h14, 32'h0,        32'hDEAD12EF, 0, 3, 1, 0, 32'h14, 2'd0, 32'h0));
    vecs.push_back(mk(0, 2'd3, 32'h17, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,  2'd0, 32'h0));

    overlap = 0;
    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // Request held valid across three word loads.
    resp_cycs.delete();
    nrd = 0; nwr = 0;
    cpu.req_write = 1'b0; cpu.req_type = 2'b00; cpu.req_addr = 32'h10; cpu.req_wdata = '0;
    cpu.req_valid = 1'b1;
    accepts = 0;
    for (int k = 0; k < 40 && accepts < 3; k++) begin
      rdy = cpu.req_ready;
      @(posedge clock); #1;
      if (rdy) accepts++;
    end
    cpu.req_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("b2b_accepts", 32'(accepts), 32'd3);
    chk("b2b_resp_count", 32'(resp_cycs.size()), 32'd3);
    chk("b2b_reads", 32'(nrd), 32'd3);
    if (resp_cycs.size() == 3) begin
      chk("b2b_gap1", 32'(resp_cycs[1] - resp_cycs[0]), 32'd4);
      chk("b2b_gap2", 32'(resp_cycs[2] - resp_cycs[1]), 32'd4);
    end
    chk("no_rd_wr_overlap", 32'(overlap), 32'd0);

    // Reset during RMW_WAIT of a byte store to 0x1A.
    resp_cycs.delete();
    nrd = 0; nwr = 0;
    cpu.req_write = 1'b1; cpu.req_type = 2'b01; cpu.req_addr = 32'h1A; cpu.req_wdata = 32'h77;
    rdy = cpu.req_ready;
    cpu.req_valid = 1'b1;
    @(posedge clock); #1;
    cpu.req_valid = 1'b0;
    chk("rmw_rst_accept", 32'(rdy), 32'd1);
    chk("rmw_rst_memread", 32'(mem.MemRead), 32'd1);
    chk("rmw_rst_rd_addr", mem.Address, 32'h18);
    @(posedge clock); #1;
    chk("rmw_rst_wait_memread", 32'(mem.MemRead), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rmw_rst_req_ready", 32'(cpu.req_ready), 32'd1);
    chk("rmw_rst_resp_valid", 32'(cpu.resp_valid), 32'd0);
    chk("rmw_rst_resp_rdata", cpu.resp_rdata, 32'd0);
    chk("rmw_rst_resp_err", 32'(cpu.resp_err), 32'd0);
    chk("rmw_rst_address", mem.Address, 32'd0);
    chk("rmw_rst_writedata", mem.WriteData, 32'd0);
    chk("rmw_rst_tipols", 32'(mem.tipols), 32'd0);
    chk("rmw_rst_memread2", 32'(mem.MemRead), 32'd0);
    chk("rmw_rst_memwrite", 32'(mem.MemWrite), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("rmw_rst_no_write", 32'(nwr), 32'd0);
    chk("rmw_rst_no_resp", 32'(resp_cycs.size()), 32'd0);
    chk("rmw_rst_mem_word", mem_arr[6], 32'hCAFEF00D);

    run_vec("post_rst", mk(0, 2'd0, 32'h18, 32'h0, 32'hCAFEF00D, 0, 3, 1, 0, 32'h18, 2'd0, 32'h0));
    chk("final_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
